// File: rtl/rgb_led_arbiter_pkg.sv
// Shared state encodings, owner codes and LED colour constants for the RGB LED arbiter.
package rgb_led_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SIREN   = 3'd1,
    ST_KEY     = 3'd2,
    ST_ERR_ON  = 3'd3,
    ST_ERR_OFF = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_SIREN = 2'd1;
  localparam logic [1:0] OWN_KEY   = 2'd2;
  localparam logic [1:0] OWN_ERR   = 2'd3;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] OFF = 3'b000;

  function automatic logic [1:0] owner_of(input state_t s);
    case (s)
      ST_SIREN:              owner_of = OWN_SIREN;
      ST_KEY:                owner_of = OWN_KEY;
      ST_ERR_ON, ST_ERR_OFF: owner_of = OWN_ERR;
      default:               owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rgb_led_arbiter_tick_prescaler.sv
// Free-running 0..DIV-1 counter emitting a one-cycle tick on its last count;
// restart forces the count back to 0 so a timed state always sees full ticks.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart || tick) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority owner of the two RGB LEDs: error flash > key echo > siren > off,
// with tick-timed holds for key and error states and registered LED outputs.
module rgb_led_arbiter #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int BLINK_TICKS = 3,
  parameter int ERR_FLASHES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       siren_en,
  input  logic [2:0] siren_rgb1,
  input  logic [2:0] siren_rgb2,
  input  logic       err_pulse,
  input  logic       key_pulse,
  input  logic [2:0] key_rgb,
  output logic [2:0] rgb1,
  output logic [2:0] rgb2,
  output logic [1:0] owner,
  output logic       busy
);
  import rgb_led_arbiter_pkg::*;

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int FW = (ERR_FLASHES > 1) ? $clog2(ERR_FLASHES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(ERR_FLASHES - 1);

  state_t        state, next_state, arb_state;
  logic          err_pend, key_pend, err_eff, key_eff;
  logic          restart, tick;
  logic [2:0]    key_color, key_color_eff;
  logic [BW-1:0] blink_cnt;
  logic [FW-1:0] flash_cnt;

  // Pulses arriving this cycle act on this edge, not one cycle later.
  assign err_eff       = err_pend | err_pulse;
  assign key_eff       = key_pend | key_pulse;
  assign key_color_eff = key_pulse ? key_rgb : key_color;

  always_comb begin
    arb_state = err_eff  ? ST_ERR_ON :
                key_eff  ? ST_KEY    :
                siren_en ? ST_SIREN  : ST_IDLE;
    next_state = state;
    case (state)
      ST_IDLE, ST_SIREN: next_state = arb_state;
      ST_KEY: begin
        if (err_eff)                          next_state = ST_ERR_ON;
        else if (key_pulse)                   next_state = ST_KEY;
        else if (tick && blink_cnt == BLINK_LAST) next_state = arb_state;
      end
      ST_ERR_ON: begin
        if (err_eff)   next_state = ST_ERR_ON;
        else if (tick) next_state = ST_ERR_OFF;
      end
      ST_ERR_OFF: begin
        if (err_eff)                        next_state = ST_ERR_ON;
        else if (tick && flash_cnt != FLASH_LAST) next_state = ST_ERR_ON;
        else if (tick)                      next_state = arb_state;
      end
      default: next_state = ST_IDLE;
    endcase
    // Transitions between timed states on a tick need no restart: the prescaler wraps anyway.
    restart = err_eff || (next_state == ST_KEY && (state != ST_KEY || key_pulse));
  end

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      err_pend  <= 1'b0;
      key_pend  <= 1'b0;
      key_color <= OFF;
      blink_cnt <= '0;
      flash_cnt <= '0;
      rgb1      <= OFF;
      rgb2      <= OFF;
      owner     <= OWN_NONE;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      err_pend  <= err_eff && (next_state != ST_ERR_ON);
      key_pend  <= key_eff && !(restart && next_state == ST_KEY);
      if (key_pulse) key_color <= key_rgb;

      if (restart)                    blink_cnt <= '0;
      else if (state == ST_KEY && tick) blink_cnt <= blink_cnt + 1'b1;

      if (err_eff) flash_cnt <= '0;
      else if (state == ST_ERR_OFF && next_state == ST_ERR_ON) flash_cnt <= flash_cnt + 1'b1;

      case (next_state)
        ST_SIREN:  begin rgb1 <= siren_rgb1;    rgb2 <= siren_rgb2; end
        ST_KEY:    begin rgb1 <= key_color_eff; rgb2 <= OFF;        end
        ST_ERR_ON: begin rgb1 <= RED;           rgb2 <= RED;        end
        default:   begin rgb1 <= OFF;           rgb2 <= OFF;        end
      endcase
      owner <= owner_of(next_state);
      busy  <= (next_state == ST_KEY) || (next_state == ST_ERR_ON) || (next_state == ST_ERR_OFF);
    end
  end

endmodule
